dcache_sram_port: RTL and testbench

Single-clock port controller sitting in front of the 512×32 simple-dual-port data-cache SRAM (byte-enabled write, unregistered read output, one-cycle read latency). It arbitrates CPU load/store requests against line-refill bursts and drives both SRAM ports. It returns load data with a fixed latency and resolves read-after-write hazards on the SRAM, either by forwarding or by a one-cycle stall.

---
 rtl/dcache_pkg.sv | 32 +++
 rtl/dcache_byte_merge.sv | 28 ++
 rtl/dcache_sram_port.sv | 220 ++++++++++++++++++++++
 tb/tb_dcache_sram_port.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_pkg
//  Purpose  : Shared definitions for the data-cache SRAM port controller:
//             default geometry of the 512x32 data SRAM, the controller state
//             encoding and the write-stage register layout.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    // Default SRAM geometry; the top-level parameters default to these.
    localparam int DCACHE_ADDR_WIDTH = 9;
    localparam int DCACHE_DATA_WIDTH = 32;
    localparam int DCACHE_BE_WIDTH   = DCACHE_DATA_WIDTH / 8;
    localparam int DCACHE_LINE_BEATS = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    // Write stage: one pending SRAM write, issued the cycle after acceptance.
    typedef struct packed {
        logic                         valid;
        logic [DCACHE_ADDR_WIDTH-1:0] addr;
        logic [DCACHE_DATA_WIDTH-1:0] data;
        logic [DCACHE_BE_WIDTH-1:0]   be;
    } wq_t;

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/dcache_byte_merge.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_byte_merge
//  Purpose  : Combinational byte-wise merge of forwarded store data over the
//             SRAM read data. A set fwd_be bit selects that byte from
//             fwd_data, a clear bit passes the SRAM byte through.
//  Ports    : fwd_be    - per-byte forward select
//             fwd_data  - forwarded (newer) store data
//             sram_data - SRAM read data (older contents)
//             merged    - merged word
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_byte_merge #(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
) (
    input  logic [BE_WIDTH-1:0]   fwd_be,
    input  logic [DATA_WIDTH-1:0] fwd_data,
    input  logic [DATA_WIDTH-1:0] sram_data,
    output logic [DATA_WIDTH-1:0] merged
);

    for (genvar i = 0; i < BE_WIDTH; i++) begin : g_byte
        assign merged[8*i +: 8] = fwd_be[i] ? fwd_data[8*i +: 8] : sram_data[8*i +: 8];
    end

endmodule : dcache_byte_merge
`default_nettype wire

// File: rtl/dcache_sram_port.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_sram_port
//  Purpose  : Port controller in front of the simple-dual-port data-cache
//             SRAM (byte-enabled write, one-cycle read latency). Arbitrates
//             CPU loads/stores against line-refill bursts, drives both SRAM
//             ports and returns load data with a fixed latency of one cycle.
//             Read-after-write collisions with the pending write are
//             resolved by forwarding (DCACHE_PORT_FWD_EN defined) or by a
//             one-cycle request stall (macro undefined, default build).
//  Ports    : clk, rst_n            - clock, async active-low reset
//             req_*                 - CPU request (valid/ready handshake)
//             rsp_valid, rsp_data   - load response, one cycle after accept
//             refill_start/line     - begin a line refill
//             refill_valid/data     - refill beats (always accepted)
//             refill_done           - pulse with the last beat's SRAM write
//             sram_wr_*             - SRAM write port
//             sram_rd_addr/data     - SRAM read port
//  Macro    : DCACHE_PORT_FWD_EN    - enable store-to-load forwarding
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_sram_port
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = DCACHE_ADDR_WIDTH,
    parameter int DATA_WIDTH = DCACHE_DATA_WIDTH,
    parameter int BE_WIDTH   = DCACHE_BE_WIDTH,
    parameter int LINE_BEATS = DCACHE_LINE_BEATS
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic                                    req_we,
    input  logic [ADDR_WIDTH-1:0]                   req_addr,
    input  logic [DATA_WIDTH-1:0]                   req_wdata,
    input  logic [BE_WIDTH-1:0]                     req_be,
    output logic                                    rsp_valid,
    output logic [DATA_WIDTH-1:0]                   rsp_data,
    input  logic                                    refill_start,
    input  logic [ADDR_WIDTH-$clog2(LINE_BEATS)-1:0] refill_line,
    input  logic                                    refill_valid,
    input  logic [DATA_WIDTH-1:0]                   refill_data,
    output logic                                    refill_done,
    output logic                                    sram_wr_en,
    output logic [ADDR_WIDTH-1:0]                   sram_wr_addr,
    output logic [DATA_WIDTH-1:0]                   sram_wr_data,
    output logic [BE_WIDTH-1:0]                     sram_wr_byte_en,
    output logic [ADDR_WIDTH-1:0]                   sram_rd_addr,
    input  logic [DATA_WIDTH-1:0]                   sram_rd_data
);

    localparam int                    BEAT_WIDTH = $clog2(LINE_BEATS);
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT  = BEAT_WIDTH'(LINE_BEATS - 1);

    state_t                  state;
    state_t                  state_next;
    logic [BEAT_WIDTH-1:0]   beat_cnt;
    wq_t                     wq;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic                    rsp_valid_q;
    logic                    refill_done_q;
    logic [DATA_WIDTH-1:0]   merged_data;

    logic                    addr_hit;
    logic                    hazard_stall;
    logic                    req_acc;
    logic                    load_acc;
    logic                    store_acc;
    logic                    beat_acc;
    logic                    last_beat;

    // A load to the address the write stage is about to write would read
    // stale data, since the SRAM returns old contents on a same-cycle
    // read/write collision.
    assign addr_hit = wq.valid && (req_addr == wq.addr);

`ifdef DCACHE_PORT_FWD_EN
    assign hazard_stall = 1'b0;
`else
    // Holding the load one cycle lets the pending write land first; the
    // write stage empties on its own because nothing is accepted.
    assign hazard_stall = req_valid && !req_we && addr_hit;
`endif

    // rst_n is folded in so the port reports not-ready throughout reset.
    assign req_ready = (state == IDLE) && !refill_start && !hazard_stall && rst_n;
    assign req_acc   = req_valid && req_ready;
    assign load_acc  = req_acc && !req_we;
    assign store_acc = req_acc && req_we;
    assign beat_acc  = (state == REFILL) && refill_valid;
    assign last_beat = beat_acc && (beat_cnt == LAST_BEAT);

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (refill_start) begin
                    state_next = REFILL;
                end
            end
            REFILL: begin
                if (last_beat) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Refill beat counter: wraps naturally since LINE_BEATS is a power of 2
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if ((state == IDLE) && refill_start) begin
            beat_cnt <= '0;
        end else if (beat_acc) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write stage; stores and refill beats are mutually exclusive because
    // requests are only accepted in IDLE and beats only in REFILL.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wq <= '0;
        end else if (store_acc) begin
            wq.valid <= 1'b1;
            wq.addr  <= req_addr;
            wq.data  <= req_wdata;
            wq.be    <= req_be;
        end else if (beat_acc) begin
            wq.valid <= 1'b1;
            wq.addr  <= {refill_line, beat_cnt};
            wq.data  <= refill_data;
            wq.be    <= '1;
        end else begin
            wq.valid <= 1'b0;
        end
    end

    assign sram_wr_en      = wq.valid;
    assign sram_wr_addr    = wq.addr;
    assign sram_wr_data    = wq.data;
    assign sram_wr_byte_en = wq.be;

    // ------------------------------------------------------------------
    // Read port and response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q     <= '0;
            rsp_valid_q   <= 1'b0;
            refill_done_q <= 1'b0;
        end else begin
            if (load_acc) begin
                rd_addr_q <= req_addr;
            end
            rsp_valid_q   <= load_acc;
            refill_done_q <= last_beat;
        end
    end

    // The accepted address goes straight to the SRAM so data returns in
    // the next cycle; otherwise the last load address is held.
    assign sram_rd_addr = load_acc ? req_addr : rd_addr_q;

`ifdef DCACHE_PORT_FWD_EN
    logic [BE_WIDTH-1:0]   fwd_be;
    logic [DATA_WIDTH-1:0] fwd_data;

    // fwd_be is zero for non-colliding loads so the merge passes the SRAM
    // data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_be   <= '0;
            fwd_data <= '0;
        end else if (load_acc) begin
            fwd_be   <= addr_hit ? wq.be : '0;
            fwd_data <= wq.data;
        end
    end

    dcache_byte_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .BE_WIDTH   (BE_WIDTH)
    ) u_byte_merge (
        .fwd_be    (fwd_be),
        .fwd_data  (fwd_data),
        .sram_data (sram_rd_data),
        .merged    (merged_data)
    );
`else
    assign merged_data = sram_rd_data;
`endif

    // Gated so rsp_data reads zero whenever no response is presented.
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_valid_q ? merged_data : '0;
    assign refill_done = refill_done_q;

endmodule : dcache_sram_port
`default_nettype wire

// File: tb/tb_dcache_sram_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_sram_port
//  Purpose  : Self-checking bench for dcache_sram_port with a behavioural
//             512x32 byte-enabled SRAM (old data on read/write collision).
//             Expected responses and SRAM writes are queued at issue time
//             and checked by independent monitors.
//  Macro    : DCACHE_PORT_FWD_EN - selects the expected hazard stall count
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_sram_port;

`ifdef DCACHE_PORT_FWD_EN
    localparam int EXP_STALL = 0;
`else
    localparam int EXP_STALL = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        refill_start;
    logic [5:0]  refill_line;
    logic        refill_valid;
    logic [31:0] refill_data;
    logic        refill_done;
    logic        sram_wr_en;
    logic [8:0]  sram_wr_addr;
    logic [31:0] sram_wr_data;
    logic [3:0]  sram_wr_byte_en;
    logic [8:0]  sram_rd_addr;
    logic [31:0] sram_rd_data;

    dcache_sram_port dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_be          (req_be),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .refill_start    (refill_start),
        .refill_line     (refill_line),
        .refill_valid    (refill_valid),
        .refill_data     (refill_data),
        .refill_done     (refill_done),
        .sram_wr_en      (sram_wr_en),
        .sram_wr_addr    (sram_wr_addr),
        .sram_wr_data    (sram_wr_data),
        .sram_wr_byte_en (sram_wr_byte_en),
        .sram_rd_addr    (sram_rd_addr),
        .sram_rd_data    (sram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: read data registered from the pre-write contents.
    logic [31:0] mem [0:511];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        rd_q <= mem[sram_rd_addr];
        if (sram_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_wr_byte_en[i]) mem[sram_wr_addr][8*i +: 8] <= sram_wr_data[8*i +: 8];
            end
        end
    end
    assign sram_rd_data = rd_q;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_exp_t;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          due;
    } wr_exp_t;

    rsp_exp_t rsp_q[$];
    wr_exp_t  wr_q[$];

    int n_vec      = 0;
    int n_err      = 0;
    int done_cnt   = 0;
    int last_waits = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------
    always @(negedge clk) begin : mon_rsp
        rsp_exp_t e;
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else begin
                e = rsp_q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_latency", cyc, e.due);
            end
        end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            void'(rsp_q.pop_front());
            chk("rsp_missing", {31'd0, rsp_valid}, 32'd1);
        end
    end

    always @(negedge clk) begin : mon_wr
        wr_exp_t w;
        if (sram_wr_en) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", {31'd0, sram_wr_en}, 32'd0);
            end else begin
                w = wr_q.pop_front();
                chk("wr_addr", {23'd0, sram_wr_addr}, {23'd0, w.addr});
                chk("wr_data", sram_wr_data, w.data);
                chk("wr_be", {28'd0, sram_wr_byte_en}, {28'd0, w.be});
                chk("wr_latency", cyc, w.due);
            end
        end else if (wr_q.size() > 0 && wr_q[0].due <= cyc) begin
            void'(wr_q.pop_front());
            chk("wr_missing", {31'd0, sram_wr_en}, 32'd1);
        end
    end

    always @(negedge clk) begin : mon_done
        if (refill_done) begin
            done_cnt++;
            chk("done_with_last_write", {28'd0, sram_wr_en, sram_wr_addr[2:0]}, 32'hF);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (entered and left at posedge + 1)
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_req(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp_rd);
        int       waits;
        rsp_exp_t re;
        wr_exp_t  we_e;
        waits     = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        @(negedge clk);
        while (!req_ready && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        chk("req_accept", {31'd0, req_ready}, 32'd1);
        if (req_ready) begin
            if (we) begin
                we_e.addr = addr;
                we_e.data = wd;
                we_e.be   = be;
                we_e.due  = cyc + 1;
                wr_q.push_back(we_e);
            end else begin
                re.data = exp_rd;
                re.due  = cyc + 1;
                rsp_q.push_back(re);
                chk("rd_addr", {23'd0, sram_rd_addr}, {23'd0, addr});
            end
        end
        last_waits = waits;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic refill(input logic [5:0] line, input logic [31:0] base, input int nbeats);
        wr_exp_t w;
        refill_start = 1'b1;
        refill_line  = line;
        @(negedge clk);
        chk("ready_low_at_start", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        refill_start = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            refill_valid = 1'b1;
            refill_data  = base + b;
            w.addr = {line, 3'(b)};
            w.data = base + b;
            w.be   = 4'hF;
            w.due  = cyc + 1;
            wr_q.push_back(w);
            @(negedge clk);
            chk("ready_low_in_refill", {31'd0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
            refill_valid = 1'b0;
            @(negedge clk);
            if (b != 7) chk("ready_low_in_gap", {31'd0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_refill_done", {31'd0, refill_done}, 32'd0);
        chk("rst_wr_en", {31'd0, sram_wr_en}, 32'd0);
        chk("rst_wr_addr", {23'd0, sram_wr_addr}, 32'd0);
        chk("rst_wr_data", sram_wr_data, 32'd0);
        chk("rst_wr_be", {28'd0, sram_wr_byte_en}, 32'd0);
        chk("rst_rd_addr", {23'd0, sram_rd_addr}, 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : stim
        int d0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_be       = '0;
        refill_start = 1'b0;
        refill_line  = '0;
        refill_valid = 1'b0;
        refill_data  = '0;

        idle(2);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Store then later load.
        do_req(1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 32'h0);
        idle(2);
        do_req(1'b0, 9'h010, 32'h0, 4'h0, 32'hDEADBEEF);
        chk("no_stall_plain_load", last_waits, 0);
        idle(2);

        // Partial store immediately followed by a colliding load.
        do_req(1'b1, 9'h020, 32'h11223344, 4'hF, 32'h0);
        do_req(1'b1, 9'h020, 32'hAABBCCDD, 4'b0101, 32'h0);
        do_req(1'b0, 9'h020, 32'h0, 4'h0, 32'h11BB33DD);
        chk("hazard_stall_cycles", last_waits, EXP_STALL);
        idle(2);

        // Store then load to a different address: no interaction.
        do_req(1'b1, 9'h030, 32'hCAFEF00D, 4'hF, 32'h0);
        do_req(1'b0, 9'h010, 32'h0, 4'h0, 32'hDEADBEEF);
        chk("no_stall_diff_addr", last_waits, 0);
        idle(2);

        // Gapped refill of line 3.
        d0 = done_cnt;
        refill(6'd3, 32'h100, 8);
        idle(2);
        chk("done_pulses_line3", done_cnt - d0, 1);
        do_req(1'b0, 9'h018, 32'h0, 4'h0, 32'h100);
        do_req(1'b0, 9'h01C, 32'h0, 4'h0, 32'h104);
        do_req(1'b0, 9'h01F, 32'h0, 4'h0, 32'h107);
        idle(2);

        // refill_start and a load in the same cycle.
        d0 = done_cnt;
        fork
            refill(6'd5, 32'h500, 8);
            do_req(1'b0, 9'h02D, 32'h0, 4'h0, 32'h505);
        join
        chk("load_held_by_refill", last_waits, 16);
        idle(2);
        chk("done_pulses_line5", done_cnt - d0, 1);

        // Load accepted the cycle before refill_start.
        do_req(1'b0, 9'h01F, 32'h0, 4'h0, 32'h107);
        refill(6'd6, 32'h600, 8);
        idle(2);

        // Reset in the middle of a refill.
        d0 = done_cnt;
        refill(6'd2, 32'h200, 4);
        rst_n        = 1'b0;
        refill_valid = 1'b1;
        refill_data  = 32'hBAD0BAD0;
        @(negedge clk);
        chk_reset_outputs();
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", {31'd0, req_ready}, 32'd1);
        idle(3);
        refill_valid = 1'b0;
        idle(2);
        chk("no_done_after_abort", done_cnt - d0, 0);
        refill(6'd2, 32'h300, 8);
        idle(2);
        chk("done_pulses_fresh", done_cnt - d0, 1);
        do_req(1'b0, 9'h013, 32'h0, 4'h0, 32'h303);
        do_req(1'b0, 9'h017, 32'h0, 4'h0, 32'h307);
        idle(2);

        // Full sweep: descending data, then read back including the wrap.
        for (int i = 0; i < 512; i++) begin
            do_req(1'b1, 9'(i), 32'h8000_0000 + 32'(511 - i), 4'hF, 32'h0);
        end
        for (int i = 0; i < 512; i++) begin
            do_req(1'b0, 9'(i), 32'h0, 4'h0, 32'h8000_0000 + 32'(511 - i));
        end
        do_req(1'b0, 9'h000, 32'h0, 4'h0, 32'h8000_01FF);
        idle(4);

        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("wr_queue_drained", wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dcache_sram_port
`default_nettype wire
